// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared types and helpers for the single-clock FIFO (sync_fifo).
//   fifo_status_t : packed bundle of the occupancy-derived status flags.
//   is_pow2()     : constant function used for elaboration-time legality checks.
// -----------------------------------------------------------------------------
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
  } fifo_status_t;

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// -----------------------------------------------------------------------------
// fifo_ram
// Storage array for sync_fifo: one synchronous write port, one combinational
// read port. The read port is combinational so a first-word-fall-through FIFO
// can present its head entry in the same cycle. Contents are not reset.
// Ports:
//   clk        : clock, write on rising edge
//   i_wr_en    : write strobe
//   i_wr_addr  : write address
//   i_wr_data  : write payload
//   i_rd_addr  : read address
//   o_rd_data  : data at i_rd_addr (combinational)
// -----------------------------------------------------------------------------
module fifo_ram #(
  parameter int WIDTH       = 32,
  parameter int NUM_ENTRIES = 8
) (
  input  logic                           clk,
  input  logic                           i_wr_en,
  input  logic [$clog2(NUM_ENTRIES)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]               i_wr_data,
  input  logic [$clog2(NUM_ENTRIES)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]               o_rd_data
);

  logic [WIDTH-1:0] r_mem [NUM_ENTRIES];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock parametrised FIFO with occupancy count, almost-full/empty
// thresholds, sticky overflow/underflow flags, synchronous flush and a
// selectable read mode (first-word-fall-through or registered output).
// Ports:
//   clk          : clock, all logic on rising edge
//   reset_n      : asynchronous active-low reset
//   flush        : synchronous clear of contents (flags untouched)
//   clear_errors : synchronous clear of overflow/underflow
//   write_en     : write request          write_data : write payload
//   read_en      : read request           read_data  : read payload
//   read_valid   : read_data qualifier
//   full / almost_full / empty / almost_empty / count : occupancy status
//   overflow     : sticky, write attempted while full
//   underflow    : sticky, read attempted while empty
// -----------------------------------------------------------------------------
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH                  = 32,
  parameter int NUM_ENTRIES            = 8,
  parameter int ALMOST_FULL_THRESHOLD  = NUM_ENTRIES - 1,
  parameter int ALMOST_EMPTY_THRESHOLD = 1,
  parameter int FWFT                   = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         clear_errors,
  input  logic                         write_en,
  input  logic [WIDTH-1:0]             write_data,
  output logic                         full,
  output logic                         almost_full,
  input  logic                         read_en,
  output logic [WIDTH-1:0]             read_data,
  output logic                         read_valid,
  output logic                         empty,
  output logic                         almost_empty,
  output logic [$clog2(NUM_ENTRIES):0] count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int ADDR_WIDTH = $clog2(NUM_ENTRIES);
  localparam int PTR_WIDTH  = ADDR_WIDTH + 1;

  typedef logic [PTR_WIDTH-1:0] ptr_t;

  localparam ptr_t PTR_ONE  = ptr_t'(1);
  localparam ptr_t FULL_CNT = ptr_t'(NUM_ENTRIES);
  localparam ptr_t AF_CNT   = ptr_t'(ALMOST_FULL_THRESHOLD);
  localparam ptr_t AE_CNT   = ptr_t'(ALMOST_EMPTY_THRESHOLD);

  // Parameter legality, rejected at elaboration.
  if (!is_pow2(NUM_ENTRIES) || NUM_ENTRIES < 2) begin : g_bad_depth
    $error("sync_fifo: NUM_ENTRIES must be a power of two >= 2");
  end
  if (ALMOST_FULL_THRESHOLD < 1 || ALMOST_FULL_THRESHOLD > NUM_ENTRIES) begin : g_bad_af
    $error("sync_fifo: ALMOST_FULL_THRESHOLD out of range 1..NUM_ENTRIES");
  end
  if (ALMOST_EMPTY_THRESHOLD < 0 || ALMOST_EMPTY_THRESHOLD > NUM_ENTRIES - 1) begin : g_bad_ae
    $error("sync_fifo: ALMOST_EMPTY_THRESHOLD out of range 0..NUM_ENTRIES-1");
  end

  ptr_t             r_wptr;
  ptr_t             r_rptr;
  ptr_t             w_count;
  fifo_status_t     w_status;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic             w_ovf_set;
  logic             w_unf_set;
  logic             r_overflow;
  logic             r_underflow;
  logic [WIDTH-1:0] w_ram_rdata;

  // Wrap bit in the MSB makes the modular difference the true occupancy,
  // including the full case (difference == NUM_ENTRIES).
  assign w_count = r_wptr - r_rptr;

  // Status comes from registered pointers only; no combinational path from
  // write_en/read_en to any status output.
  always_comb begin
    w_status              = '0;
    w_status.full         = (w_count == FULL_CNT);
    w_status.almost_full  = (w_count >= AF_CNT);
    w_status.empty        = (w_count == '0);
    w_status.almost_empty = (w_count <= AE_CNT);
  end

  // Flush blocks both acceptance and error-flag setting in its cycle.
  assign w_wr_acc  = write_en && !w_status.full  && !flush;
  assign w_rd_acc  = read_en  && !w_status.empty && !flush;
  assign w_ovf_set = write_en &&  w_status.full  && !flush;
  assign w_unf_set = read_en  &&  w_status.empty && !flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_rd_acc) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
    end
  end

  // Sticky flags: a set in the same cycle as clear_errors wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= w_ovf_set | (r_overflow  & ~clear_errors);
      r_underflow <= w_unf_set | (r_underflow & ~clear_errors);
    end
  end

  fifo_ram #(
    .WIDTH       (WIDTH),
    .NUM_ENTRIES (NUM_ENTRIES)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wptr[ADDR_WIDTH-1:0]),
    .i_wr_data (write_data),
    .i_rd_addr (r_rptr[ADDR_WIDTH-1:0]),
    .o_rd_data (w_ram_rdata)
  );

  if (FWFT != 0) begin : g_fwft
    // Head entry visible whenever the FIFO is non-empty.
    assign read_data  = w_ram_rdata;
    assign read_valid = !w_status.empty;
  end else begin : g_regout
    logic [WIDTH-1:0] r_read_data;
    logic             r_read_valid;

    // Data register holds its last value when no read is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_read_data  <= '0;
        r_read_valid <= 1'b0;
      end else begin
        r_read_valid <= w_rd_acc;
        if (w_rd_acc) begin
          r_read_data <= w_ram_rdata;
        end
      end
    end

    assign read_data  = r_read_data;
    assign read_valid = r_read_valid;
  end

  assign full         = w_status.full;
  assign almost_full  = w_status.almost_full;
  assign empty        = w_status.empty;
  assign almost_empty = w_status.almost_empty;
  assign count        = w_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock, parametrised FIFO; the same-domain successor to the team's dual-clock FIFO, used wherever producer and consumer share a clock.
- Adds occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags, synchronous flush, and a selectable read mode: first-word-fall-through or registered output.

Parameters:
- WIDTH, 32, data width in bits.
- NUM_ENTRIES, 8, depth; power of two, >= 2.
- ALMOST_FULL_THRESHOLD, NUM_ENTRIES-1, almost_full asserts when count >= this; range 1..NUM_ENTRIES.
- ALMOST_EMPTY_THRESHOLD, 1, almost_empty asserts when count <= this; range 0..NUM_ENTRIES-1.
- FWFT, 1, 1 = read_data shows head entry combinationally; 0 = read_data registered, one-cycle read latency.

Ports:
- clk  input  1  sole clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of contents.
- clear_errors  input  1  synchronous clear of the sticky overflow/underflow flags.
- write_en  input  1  write request.
- write_data  input  WIDTH  write payload.
- full  output  1  count == NUM_ENTRIES.
- almost_full  output  1  count >= ALMOST_FULL_THRESHOLD.
- read_en  input  1  read request.
- read_data  output  WIDTH  read payload.
- read_valid  output  1  read_data qualifier.
- empty  output  1  count == 0.
- almost_empty  output  1  count <= ALMOST_EMPTY_THRESHOLD.
- count  output  $clog2(NUM_ENTRIES)+1  current occupancy.
- overflow  output  1  sticky; a write was attempted while full.
- underflow  output  1  sticky; a read was attempted while empty.

Behaviour:
- Pointers: binary, ADDR_WIDTH+1 bits (ADDR_WIDTH = $clog2(NUM_ENTRIES)). MSB is the wrap bit; the low bits address storage. count = wptr - rptr, modulo 2^(ADDR_WIDTH+1).
- Status: full, empty, almost_* and count are derived from the registered pointers only. They update the cycle after an accepted operation; none depend combinationally on write_en or read_en.
- Write accept: write_en && !full. Read accept: read_en && !empty.
- Simultaneous write and read:
  - when full: only the read is accepted, count drops by 1, overflow sets.
  - when empty: only the write is accepted, count rises by 1, underflow sets.
  - otherwise: both are accepted and count is unchanged.
- Error flags:
  - overflow is set on write_en && full; underflow is set on read_en && empty.
  - Both take effect the next cycle and hold until clear_errors or reset.
  - If set and clear occur in the same cycle, set wins.
- flush:
  - Next cycle wptr = rptr = 0, count = 0, read_valid = 0.
  - Takes priority over write_en and read_en in the same cycle; neither is accepted and neither error flag sets.
  - Does not clear the sticky flags.
- Storage: not reset.
- FWFT=1: read_data = mem[rptr] combinationally; read_valid = !empty. read_data is undefined while empty and must not be checked.
- FWFT=0:
  - On an accepted read, the read_data register loads mem[rptr] and read_valid = 1 the next cycle.
  - Otherwise read_valid = 0 and read_data holds its last value.
  - Back-to-back reads give one word per cycle.
- Reset (reset_n low, asynchronous): wptr = rptr = 0; count 0; empty 1; almost_empty 1; full 0; almost_full 0; read_valid 0; overflow 0; underflow 0; registered read_data 0.
- Reset mid-operation discards all contents. The first write after release is accepted on the first rising edge with reset_n high.
- Pointers wrap naturally at 2^(ADDR_WIDTH+1); data order is preserved across wrap.

Decomposition:
- Package fifo_pkg:
  - fifo_status_t, packed struct {full, almost_full, empty, almost_empty}.
  - Parameter-legality checks (power-of-two depth, threshold ranges) as elaboration-time assertions in the module.
- Sub-module fifo_ram (WIDTH, NUM_ENTRIES): one synchronous write port and one combinational read port. sync_fifo owns pointers, status and the output register.

Test Plan (WIDTH=32, NUM_ENTRIES=8, AF=6, AE=2 unless stated):
- Reset then write 0x11..0x88 (8 words) -> count steps 1..8; almost_empty drops after count 3; almost_full at count 6; full at 8. A 9th write leaves count 8 and sets overflow.
- Read all 8 with FWFT=1 -> read_data = 0x11..0x88 in order; empty after the last read. One further read_en sets underflow; clear_errors clears it.
- Fill to 8, assert write_en+read_en for 1 cycle -> count 7, overflow=1. At count 4, write_en+read_en for 20 cycles -> count stays 4, data order correct across pointer wrap.
- FWFT=0: write 0xA5A5A5A5, 0x5A5A5A5A; read 2 back-to-back -> read_valid high for the 2 cycles following the reads, data in order; read_valid low otherwise.
- At count 5, assert flush together with write_en -> next cycle count 0, empty 1, no write stored, overflow/underflow unchanged.
- Drop reset_n asynchronously mid-burst at count 3 -> all outputs take reset values immediately; write 0x77 after release -> read_data 0x77, count 1.
